// File: rtl/addsub_share_ctrl.sv
// Round-robin front end for one shared external WIDTH-bit adder/subtractor.
// Two requesters take turns; operands are registered toward the adder and the result is registered back.
//
// state | meaning
// IDLE  | waiting for a request; readies follow valids and rr_ptr
// EXEC  | registered operands settle through the external adder
// RESP  | result held on rsp_*; waiting for the granted port's rsp_ready
module addsub_share_ctrl #(
  parameter int WIDTH     = 5,
  parameter int OVF_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [WIDTH-1:0]     req0_x,
  input  logic [WIDTH-1:0]     req0_y,
  input  logic                 req0_sub,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [WIDTH-1:0]     req1_x,
  input  logic [WIDTH-1:0]     req1_y,
  input  logic                 req1_sub,
  output logic                 rsp0_valid,
  input  logic                 rsp0_ready,
  output logic                 rsp1_valid,
  input  logic                 rsp1_ready,
  output logic [WIDTH-1:0]     rsp_s,
  output logic                 rsp_c5,
  output logic                 rsp_e,
  output logic [WIDTH-1:0]     alu_x,
  output logic [WIDTH-1:0]     alu_y,
  output logic                 alu_sub,
  input  logic [WIDTH-1:0]     alu_s,
  input  logic                 alu_c5,
  input  logic                 alu_e,
  output logic                 busy,
  output logic [OVF_CNT_W-1:0] ovf_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [OVF_CNT_W-1:0] OVF_ONE = {{(OVF_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [OVF_CNT_W-1:0] OVF_MAX = {OVF_CNT_W{1'b1}};

  state_t                state_q, state_d;
  logic                  rr_ptr_q, rr_ptr_d;
  logic                  gnt_id_q, gnt_id_d;
  logic [WIDTH-1:0]      alu_x_q, alu_x_d;
  logic [WIDTH-1:0]      alu_y_q, alu_y_d;
  logic                  alu_sub_q, alu_sub_d;
  logic [WIDTH-1:0]      rsp_s_q, rsp_s_d;
  logic                  rsp_c5_q, rsp_c5_d;
  logic                  rsp_e_q, rsp_e_d;
  logic [OVF_CNT_W-1:0]  ovf_cnt_q, ovf_cnt_d;

  logic gnt0, gnt1;

  // A lone requester wins regardless of rr_ptr; rr_ptr only breaks ties.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == IDLE) begin
      gnt0 = req0_valid && (!req1_valid || !rr_ptr_q);
      gnt1 = req1_valid && (!req0_valid ||  rr_ptr_q);
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_id_d  = gnt_id_q;
    alu_x_d   = alu_x_q;
    alu_y_d   = alu_y_q;
    alu_sub_d = alu_sub_q;
    rsp_s_d   = rsp_s_q;
    rsp_c5_d  = rsp_c5_q;
    rsp_e_d   = rsp_e_q;
    ovf_cnt_d = ovf_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (gnt0) begin
          alu_x_d   = req0_x;
          alu_y_d   = req0_y;
          alu_sub_d = req0_sub;
          gnt_id_d  = 1'b0;
          rr_ptr_d  = 1'b1;
          state_d   = EXEC;
        end else if (gnt1) begin
          alu_x_d   = req1_x;
          alu_y_d   = req1_y;
          alu_sub_d = req1_sub;
          gnt_id_d  = 1'b1;
          rr_ptr_d  = 1'b0;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        rsp_s_d  = alu_s;
        rsp_c5_d = alu_c5;
        rsp_e_d  = alu_e;
        if (alu_e && (ovf_cnt_q != OVF_MAX)) ovf_cnt_d = ovf_cnt_q + OVF_ONE;
        state_d  = RESP;
      end
      RESP: begin
        if (gnt_id_q ? rsp1_ready : rsp0_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_ptr_q  <= 1'b0;
      gnt_id_q  <= 1'b0;
      alu_x_q   <= '0;
      alu_y_q   <= '0;
      alu_sub_q <= 1'b0;
      rsp_s_q   <= '0;
      rsp_c5_q  <= 1'b0;
      rsp_e_q   <= 1'b0;
      ovf_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_id_q  <= gnt_id_d;
      alu_x_q   <= alu_x_d;
      alu_y_q   <= alu_y_d;
      alu_sub_q <= alu_sub_d;
      rsp_s_q   <= rsp_s_d;
      rsp_c5_q  <= rsp_c5_d;
      rsp_e_q   <= rsp_e_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign rsp0_valid = (state_q == RESP) && !gnt_id_q;
  assign rsp1_valid = (state_q == RESP) &&  gnt_id_q;
  assign rsp_s      = rsp_s_q;
  assign rsp_c5     = rsp_c5_q;
  assign rsp_e      = rsp_e_q;
  assign alu_x      = alu_x_q;
  assign alu_y      = alu_y_q;
  assign alu_sub    = alu_sub_q;
  assign busy       = (state_q != IDLE);
  assign ovf_count  = ovf_cnt_q;

endmodule

// File: tb/tb_addsub_share_ctrl.sv
// Directed bench for addsub_share_ctrl; the shared 5-bit adder is modelled here.
module tb_addsub_share_ctrl;
  localparam int W  = 5;
  localparam int OW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req0_ready, req0_sub;
  logic [W-1:0]  req0_x, req0_y;
  logic          req1_valid, req1_ready, req1_sub;
  logic [W-1:0]  req1_x, req1_y;
  logic          rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [W-1:0]  rsp_s;
  logic          rsp_c5, rsp_e;
  logic [W-1:0]  alu_x, alu_y, alu_s;
  logic          alu_sub, alu_c5, alu_e;
  logic          busy;
  logic [OW-1:0] ovf_count;

  int n_checks = 0;
  int n_fail   = 0;

  // External adder: X + (sub ? ~Y : Y) + sub, overflow = carry into MSB ^ carry out
  logic [W-1:0] ymod;
  logic [W:0]   full;
  logic [4:0]   low4;
  assign ymod   = alu_sub ? ~alu_y : alu_y;
  assign full   = {1'b0, alu_x} + {1'b0, ymod} + {5'b0, alu_sub};
  assign low4   = {1'b0, alu_x[3:0]} + {1'b0, ymod[3:0]} + {4'b0, alu_sub};
  assign alu_s  = full[W-1:0];
  assign alu_c5 = full[W];
  assign alu_e  = low4[4] ^ full[W];

  always #5 clk = ~clk;

  addsub_share_ctrl #(.WIDTH(W), .OVF_CNT_W(OW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y), .req1_sub(req1_sub),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_s(rsp_s), .rsp_c5(rsp_c5), .rsp_e(rsp_e),
    .alu_x(alu_x), .alu_y(alu_y), .alu_sub(alu_sub),
    .alu_s(alu_s), .alu_c5(alu_c5), .alu_e(alu_e),
    .busy(busy), .ovf_count(ovf_count)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 0; req0_x = 0; req0_y = 0; req0_sub = 0;
    req1_valid = 0; req1_x = 0; req1_y = 0; req1_sub = 0;
    rsp0_ready = 0; rsp1_ready = 0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [30:0] got;
    do_reset();
    got = {busy, rsp0_valid, rsp1_valid, req0_ready, req1_ready, alu_x, alu_y, alu_sub,
           rsp_s, rsp_c5, rsp_e, ovf_count};
    n_checks++;
    if (got !== 31'd0) begin
      $display("FAIL reset_state got %h exp 0", got); n_fail++;
    end
  endtask

  task automatic test_single_p0();
    req0_valid = 1; req0_x = 5'd7; req0_y = 5'd5; req0_sub = 0;
    #1;
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      $display("FAIL p0_ready got %b exp 10", {req0_ready, req1_ready}); n_fail++;
    end
    tick();
    req0_valid = 0;
    n_checks++;
    if ({busy, alu_x, alu_y, alu_sub, rsp0_valid} !== {1'b1, 5'd7, 5'd5, 1'b0, 1'b0}) begin
      $display("FAIL p0_exec got busy=%b x=%0d y=%0d sub=%b v=%b exp 1 7 5 0 0",
               busy, alu_x, alu_y, alu_sub, rsp0_valid); n_fail++;
    end
    tick();
    n_checks++;
    if ({rsp0_valid, rsp1_valid, rsp_s, rsp_c5, rsp_e} !== {1'b1, 1'b0, 5'b01100, 1'b0, 1'b0}) begin
      $display("FAIL p0_resp got v0=%b v1=%b s=%b c5=%b e=%b exp 1 0 01100 0 0",
               rsp0_valid, rsp1_valid, rsp_s, rsp_c5, rsp_e); n_fail++;
    end
    rsp0_ready = 1;
    tick();
    rsp0_ready = 0;
    n_checks++;
    if ({busy, rsp0_valid} !== 2'b00) begin
      $display("FAIL p0_done got busy=%b v0=%b exp 0 0", busy, rsp0_valid); n_fail++;
    end
    req0_valid = 1; req1_valid = 1;
    #1;
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      $display("FAIL rr_after_p0 got %b exp 01", {req0_ready, req1_ready}); n_fail++;
    end
    req0_valid = 0; req1_valid = 0;
  endtask

  task automatic test_single_p1();
    req1_valid = 1; req1_x = 5'd15; req1_y = 5'd3; req1_sub = 1;
    #1;
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      $display("FAIL p1_ready got %b exp 01", {req0_ready, req1_ready}); n_fail++;
    end
    tick();
    req1_valid = 0;
    n_checks++;
    if ({alu_x, alu_y, alu_sub} !== {5'd15, 5'd3, 1'b1}) begin
      $display("FAIL p1_exec got x=%0d y=%0d sub=%b exp 15 3 1", alu_x, alu_y, alu_sub); n_fail++;
    end
    tick();
    n_checks++;
    if ({rsp1_valid, rsp0_valid, rsp_s, rsp_c5, rsp_e} !== {1'b1, 1'b0, 5'b01100, 1'b1, 1'b0}) begin
      $display("FAIL p1_resp got v1=%b v0=%b s=%b c5=%b e=%b exp 1 0 01100 1 0",
               rsp1_valid, rsp0_valid, rsp_s, rsp_c5, rsp_e); n_fail++;
    end
    rsp0_ready = 1;
    tick();
    n_checks++;
    if ({rsp1_valid, busy} !== 2'b11) begin
      $display("FAIL p1_wrong_ready got v1=%b busy=%b exp 1 1", rsp1_valid, busy); n_fail++;
    end
    rsp0_ready = 0; rsp1_ready = 1;
    tick();
    rsp1_ready = 0;
    n_checks++;
    if ({busy, rsp1_valid} !== 2'b00) begin
      $display("FAIL p1_done got busy=%b v1=%b exp 0 0", busy, rsp1_valid); n_fail++;
    end
  endtask

  task automatic test_both_valid();
    do_reset();
    req0_valid = 1; req0_x = 5'd15; req0_y = 5'd15; req0_sub = 0;
    req1_valid = 1; req1_x = 5'd0;  req1_y = 5'd1;  req1_sub = 1;
    #1;
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      $display("FAIL both_grant got %b exp 10", {req0_ready, req1_ready}); n_fail++;
    end
    tick();
    req0_valid = 0;
    n_checks++;
    if ({req0_ready, req1_ready, busy} !== 3'b001) begin
      $display("FAIL both_exec got %b exp 001", {req0_ready, req1_ready, busy}); n_fail++;
    end
    tick();
    n_checks++;
    if ({rsp0_valid, rsp1_valid, rsp_s, rsp_c5, rsp_e, ovf_count, req1_ready} !==
        {1'b1, 1'b0, 5'b11110, 1'b0, 1'b1, 8'd1, 1'b0}) begin
      $display("FAIL both_resp0 got v0=%b v1=%b s=%b c5=%b e=%b ovf=%0d r1=%b exp 1 0 11110 0 1 1 0",
               rsp0_valid, rsp1_valid, rsp_s, rsp_c5, rsp_e, ovf_count, req1_ready); n_fail++;
    end
    rsp0_ready = 1;
    tick();
    rsp0_ready = 0;
    #1;
    n_checks++;
    if (req1_ready !== 1'b1) begin
      $display("FAIL both_r1_after got %b exp 1", req1_ready); n_fail++;
    end
    tick();
    req1_valid = 0;
    tick();
    n_checks++;
    if ({rsp1_valid, rsp0_valid, rsp_s, rsp_c5, rsp_e, ovf_count} !==
        {1'b1, 1'b0, 5'b11111, 1'b0, 1'b0, 8'd1}) begin
      $display("FAIL both_resp1 got v1=%b v0=%b s=%b c5=%b e=%b ovf=%0d exp 1 0 11111 0 0 1",
               rsp1_valid, rsp0_valid, rsp_s, rsp_c5, rsp_e, ovf_count); n_fail++;
    end
    rsp1_ready = 1;
    tick();
    rsp1_ready = 0;
  endtask

  task automatic test_backpressure();
    req0_valid = 1; req0_x = 5'd7; req0_y = 5'd5; req0_sub = 0;
    tick();
    req0_valid = 0;
    tick();
    req0_valid = 1; req1_valid = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if ({rsp0_valid, rsp_s, rsp_c5, rsp_e, req0_ready, req1_ready, busy} !==
          {1'b1, 5'd12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
        $display("FAIL bp_hold[%0d] got v0=%b s=%0d c5=%b e=%b r0=%b r1=%b busy=%b exp 1 12 0 0 0 0 1",
                 i, rsp0_valid, rsp_s, rsp_c5, rsp_e, req0_ready, req1_ready, busy); n_fail++;
      end
      tick();
    end
    req0_valid = 0; req1_valid = 0;
    rsp0_ready = 1;
    #1;
    n_checks++;
    if (rsp0_valid !== 1'b1) begin
      $display("FAIL bp_last got %b exp 1", rsp0_valid); n_fail++;
    end
    tick();
    rsp0_ready = 0;
    n_checks++;
    if ({busy, rsp0_valid} !== 2'b00) begin
      $display("FAIL bp_idle got busy=%b v0=%b exp 0 0", busy, rsp0_valid); n_fail++;
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    req0_valid = 1; req0_x = 5'd15; req0_y = 5'd15; req0_sub = 0;
    tick();
    req0_valid = 0;
    rst_n = 0;
    tick();
    rst_n = 1;
    n_checks++;
    if ({busy, rsp0_valid, rsp1_valid, ovf_count, alu_x} !== 16'd0) begin
      $display("FAIL mid_rst got busy=%b v0=%b v1=%b ovf=%0d x=%0d exp all 0",
               busy, rsp0_valid, rsp1_valid, ovf_count, alu_x); n_fail++;
    end
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (rsp0_valid || rsp1_valid) seen = 1;
      tick();
    end
    n_checks++;
    if (seen !== 1'b0) begin
      $display("FAIL mid_no_rsp got %b exp 0", seen); n_fail++;
    end
    req0_valid = 1; req0_x = 5'd7; req0_y = 5'd5; req0_sub = 0;
    req1_valid = 1;
    #1;
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      $display("FAIL mid_rr got %b exp 10", {req0_ready, req1_ready}); n_fail++;
    end
    req1_valid = 0;
    tick();
    req0_valid = 0;
    tick();
    n_checks++;
    if ({rsp0_valid, rsp_s, ovf_count} !== {1'b1, 5'd12, 8'd0}) begin
      $display("FAIL mid_after got v0=%b s=%0d ovf=%0d exp 1 12 0", rsp0_valid, rsp_s, ovf_count); n_fail++;
    end
    rsp0_ready = 1;
    tick();
    rsp0_ready = 0;
  endtask

  task automatic test_saturate();
    int guard;
    rsp0_ready = 1;
    req0_x = 5'd15; req0_y = 5'd15; req0_sub = 0;
    for (int k = 1; k <= 256; k++) begin
      req0_valid = 1;
      guard = 0;
      #1;
      while (!req0_ready && guard < 6) begin
        tick(); #1; guard++;
      end
      if (!req0_ready) begin
        n_checks++; n_fail++;
        $display("FAIL sat_accept_timeout k=%0d got ready=%b exp 1", k, req0_ready);
        req0_valid = 0;
        rsp0_ready = 0;
        return;
      end
      tick();
      req0_valid = 0;
      guard = 0;
      while (!rsp0_valid && guard < 6) begin
        tick(); guard++;
      end
      if (!rsp0_valid) begin
        n_checks++; n_fail++;
        $display("FAIL sat_rsp_timeout k=%0d got valid=%b exp 1", k, rsp0_valid);
        rsp0_ready = 0;
        return;
      end
      tick();
      if (k == 1 || k == 255 || k == 256) begin
        n_checks++;
        if (ovf_count !== ((k == 1) ? 8'd1 : 8'd255)) begin
          $display("FAIL sat_count k=%0d got %0d exp %0d", k, ovf_count, (k == 1) ? 1 : 255); n_fail++;
        end
      end
    end
    rsp0_ready = 0;
  endtask

  initial begin
    rst_n = 0;
    req0_valid = 0; req0_x = 0; req0_y = 0; req0_sub = 0;
    req1_valid = 0; req1_x = 0; req1_y = 0; req1_sub = 0;
    rsp0_ready = 0; rsp1_ready = 0;
    @(negedge clk);
    test_reset();
    test_single_p0();
    test_single_p1();
    test_both_valid();
    test_backpressure();
    test_reset_mid();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
